// File: rtl/mem_pkg.sv
// Shared constants, FSM encoding and address-range helper for the data memory responder.
package mem_pkg;

    localparam int unsigned DATA_W_DFLT     = 16;
    localparam int unsigned ADDR_BITS_DFLT  = 8;
    localparam int unsigned REQ_ADDR_W      = 16;
    localparam int unsigned WAIT_STATES_MAX = 15;
    localparam int unsigned CNT_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True when no address bit above the implemented range is set.
    function automatic logic addr_in_range(input logic [REQ_ADDR_W-1:0] addr,
                                           input int unsigned bits);
        return (addr >> bits) == '0;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word-addressed storage: synchronous write, combinational read, contents survive reset.
module data_mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DFLT,
    parameter int unsigned ADDR_BITS = ADDR_BITS_DFLT
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata_c
);

    logic [DATA_W-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata_c = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding memory responder with configurable wait states, flush and range checking.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DFLT,
    parameter int unsigned ADDR_BITS   = ADDR_BITS_DFLT,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [REQ_ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

    state_t                  state, state_next;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic                    cap_we;
    logic [REQ_ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]       cap_wdata;

    logic                    accept_c, enter_resp_c, leave_resp_c, mem_we_c;
    logic                    ent_we, ent_in_range;
    logic [REQ_ADDR_W-1:0]   ent_addr;
    logic [DATA_W-1:0]       ent_wdata, mem_rdata_c;

    // Held low while in reset even though the state register already reads IDLE.
    assign req_ready = resetn && (state == ST_IDLE) && !flush;

    // With zero wait states RESP is entered on the acceptance edge, so use live request fields.
    assign ent_we       = (state == ST_IDLE) ? req_we    : cap_we;
    assign ent_addr     = (state == ST_IDLE) ? req_addr  : cap_addr;
    assign ent_wdata    = (state == ST_IDLE) ? req_wdata : cap_wdata;
    assign ent_in_range = addr_in_range(ent_addr, ADDR_BITS);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept_c) state_next = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: begin
                if (flush)           state_next = ST_IDLE;
                else if (cnt == '0)  state_next = ST_RESP;
            end
            ST_RESP: if (flush || (rsp_valid && rsp_ready)) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        accept_c     = req_valid && req_ready;
        enter_resp_c = 1'b0;
        leave_resp_c = 1'b0;
        cnt_next     = cnt;
        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    cnt_next     = WAIT_LOAD;
                    enter_resp_c = (WAIT_STATES == 0);
                end
            end
            ST_WAIT: begin
                if (!flush) begin
                    if (cnt == '0) enter_resp_c = 1'b1;
                    else           cnt_next     = cnt - CNT_W'(1);
                end
            end
            ST_RESP: leave_resp_c = flush || (rsp_valid && rsp_ready);
            default: cnt_next = '0;
        endcase
        mem_we_c = enter_resp_c && ent_we && ent_in_range;
    end

    // Captured request, wait counter and registered response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            cnt <= cnt_next;
            if (accept_c) begin
                cap_we    <= req_we;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
            end
            if (enter_resp_c) begin
                rsp_valid <= 1'b1;
                rsp_err   <= !ent_in_range;
                rsp_rdata <= (ent_in_range && !ent_we) ? mem_rdata_c : '0;
            end else if (leave_resp_c) begin
                rsp_valid <= 1'b0;
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
        end
    end

    data_mem_array #(
        .DATA_W    (DATA_W),
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk     (clk),
        .we      (mem_we_c),
        .addr    (ent_addr[ADDR_BITS-1:0]),
        .wdata   (ent_wdata),
        .rdata_c (mem_rdata_c)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: one instance with two wait states, one with none.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        resetn, flush, req_valid, req_we, rsp_ready, sel;
    logic [15:0] req_addr, req_wdata;

    logic        rv_a, rv_b;
    logic        rdy_a, rdy_b, vld_a, vld_b, err_a, err_b;
    logic [15:0] rdata_a, rdata_b;
    logic        rdy, vld, err;
    logic [15:0] rdata;

    logic [15:0] m_a [256];
    logic [15:0] m_b [256];
    int          n_chk = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    // sel steers the request to instance b (no wait states) or a (two wait states).
    assign rv_a  = req_valid & ~sel;
    assign rv_b  = req_valid & sel;
    assign rdy   = sel ? rdy_b   : rdy_a;
    assign vld   = sel ? vld_b   : vld_a;
    assign err   = sel ? err_b   : err_a;
    assign rdata = sel ? rdata_b : rdata_a;

    data_mem_responder #(.DATA_W(16), .ADDR_BITS(8), .WAIT_STATES(2)) dut_a (
        .clk(clk), .resetn(resetn), .flush(flush),
        .req_valid(rv_a), .req_ready(rdy_a), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(vld_a), .rsp_ready(rsp_ready), .rsp_rdata(rdata_a), .rsp_err(err_a)
    );

    data_mem_responder #(.DATA_W(16), .ADDR_BITS(8), .WAIT_STATES(0)) dut_b (
        .clk(clk), .resetn(resetn), .flush(flush),
        .req_valid(rv_b), .req_ready(rdy_b), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(vld_b), .rsp_ready(rsp_ready), .rsp_rdata(rdata_b), .rsp_err(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_rd(input logic [15:0] addr);
        if (addr[15:8] != 8'h00) return 16'h0000;
        return sel ? m_b[addr[7:0]] : m_a[addr[7:0]];
    endfunction

    task automatic model_wr(input logic [15:0] addr, input logic [15:0] data);
        if (addr[15:8] == 8'h00) begin
            if (sel) m_b[addr[7:0]] = data;
            else     m_a[addr[7:0]] = data;
        end
    endtask

    // Present one request, wait for acceptance, then checks latency, payload, hold and release.
    task automatic txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                       input int hold);
        logic [15:0] exp_d;
        logic        exp_e;
        int          n, lat, exp_lat;
        exp_lat = sel ? 1 : 3;
        exp_e   = (addr[15:8] != 8'h00);
        exp_d   = (we || exp_e) ? 16'h0000 : model_rd(addr);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; rsp_ready = 1'b0;
        n = 0;
        while (!rdy && n < 20) begin @(negedge clk); n++; end
        if (!rdy) begin chk("accept_timeout", 0, 1); req_valid = 1'b0; return; end
        @(posedge clk);
        if (we) model_wr(addr, wdata);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!vld && lat < 40) begin @(negedge clk); lat++; end
        chk("latency", 32'(lat), 32'(exp_lat));
        if (!vld) return;
        chk("rdata", 32'(rdata), 32'(exp_d));
        chk("err", 32'(err), 32'(exp_e));
        chk("ready_busy", 32'(rdy), 0);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", 32'(vld), 1);
            chk("hold_rdata", 32'(rdata), 32'(exp_d));
            chk("hold_ready", 32'(rdy), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_valid", 32'(vld), 0);
        chk("post_ready", 32'(rdy), 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] q [$];
        logic [15:0] a, d;
        logic        took, prev_we, seen;
        int          acc, got, last, n;

        resetn = 1'b0; flush = 1'b0; req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b0;
        req_addr = '0; req_wdata = '0; sel = 1'b0;
        #2;
        chk("rst_ready_a", 32'(rdy_a), 0);
        chk("rst_ready_b", 32'(rdy_b), 0);
        chk("rst_valid_a", 32'(vld_a), 0);
        chk("rst_rdata_a", 32'(rdata_a), 0);
        chk("rst_err_b", 32'(err_b), 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rel_ready_a", 32'(rdy_a), 1);
        chk("rel_ready_b", 32'(rdy_b), 1);

        // Give every word of both arrays a known value.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int i = 0; i < 256; i++) txn(1'b1, 16'(i), 16'($urandom), 0);
        end

        sel = 1'b0;
        txn(1'b1, 16'h0010, 16'hBEEF, 0);
        txn(1'b0, 16'h0010, 16'h0000, 0);
        txn(1'b0, 16'h0100, 16'h0000, 0);
        txn(1'b1, 16'h0100, 16'h5555, 0);
        txn(1'b0, 16'h0000, 16'h0000, 0);
        txn(1'b0, 16'h0033, 16'h0000, 5);

        // flush in IDLE blocks acceptance; flush in WAIT kills the write.
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0005; req_wdata = 16'h1234;
        #1;
        chk("flush_idle_ready", 32'(rdy), 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_wait_ready", 32'(rdy), 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        seen = 1'b0;
        repeat (6) begin @(negedge clk); seen = seen | vld; end
        chk("flush_wait_no_rsp", 32'(seen), 0);
        chk("flush_wait_ready2", 32'(rdy), 1);
        txn(1'b0, 16'h0005, 16'h0000, 0);

        // flush together with rsp_ready in RESP drops the response; the write stays committed.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0007; req_wdata = 16'hC0DE;
        @(posedge clk);
        model_wr(16'h0007, 16'hC0DE);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!vld && n < 20) begin @(negedge clk); n++; end
        chk("flush_resp_valid", 32'(vld), 1);
        flush = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; rsp_ready = 1'b0;
        #1;
        chk("flush_resp_drop", 32'(vld), 0);
        chk("flush_resp_ready", 32'(rdy), 1);
        txn(1'b0, 16'h0007, 16'h0000, 0);

        // Reset while a response is pending clears outputs immediately.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0100;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", 32'(vld), 1);
        chk("rst_resp_err", 32'(err), 1);
        resetn = 1'b0;
        #1;
        chk("rst_resp_vld0", 32'(vld), 0);
        chk("rst_resp_err0", 32'(err), 0);
        chk("rst_resp_rdy0", 32'(rdy), 0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rst_resp_rel", 32'(rdy), 1);

        // Reset during WAIT discards the pending write.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0009; req_wdata = ~m_a[9];
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; resetn = 1'b0;
        #1;
        chk("rst_wait_vld", 32'(vld), 0);
        chk("rst_wait_rdy", 32'(rdy), 0);
        chk("rst_wait_rdata", 32'(rdata), 0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rst_wait_rel", 32'(rdy), 1);
        txn(1'b0, 16'h0009, 16'h0000, 0);
        txn(1'b0, 16'h0010, 16'h0000, 0);

        // Zero wait states, back-to-back reads with rsp_ready tied high.
        sel = 1'b1;
        txn(1'b0, 16'h0010, 16'h0000, 2);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; rsp_ready = 1'b1; req_addr = 16'(8'($urandom));
        acc = 0; got = 0; last = -1; took = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (took) begin req_addr = 16'(8'($urandom)); took = 1'b0; end
            if (acc == 10) req_valid = 1'b0;
            #1;
            if (vld) begin
                if (q.size() == 0) chk("tp_spurious", 1, 0);
                else chk("tp_rdata", 32'(rdata), 32'(q.pop_front()));
                if (last >= 0) chk("tp_gap", 32'(c - last), 2);
                last = c;
                got++;
            end
            if (req_valid && rdy) begin
                q.push_back(m_b[req_addr[7:0]]);
                acc++;
                took = 1'b1;
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        chk("tp_count", 32'(got), 10);

        // Random traffic across both instances.
        prev_we = 1'b0; a = 16'h0000;
        for (int i = 0; i < 80; i++) begin
            sel = 1'($urandom);
            if (prev_we && ($urandom % 3 == 0)) begin
                txn(1'b0, a, 16'h0000, 0);
                prev_we = 1'b0;
            end else begin
                if ($urandom % 6 == 0) a = {8'($urandom_range(1, 255)), 8'($urandom)};
                else                   a = {8'h00, 8'($urandom)};
                d = 16'($urandom);
                prev_we = 1'($urandom);
                txn(prev_we, a, d, int'($urandom % 4));
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width.
REQ-002 SHALL have parameter ADDR_BITS, default 8, implemented address bits (2^ADDR_BITS words).
REQ-003 SHALL have parameter WAIT_STATES, default 2, extra cycles between request acceptance and response; legal range 0..15.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; ports are clk and resetn.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 resetn  input  1  asynchronous active-low reset.
REQ-007 flush  input  1  abort the in-flight transaction (pipeline flush).
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  request accepted when high with req_valid.
REQ-010 req_we  input  1  1 = write, 0 = read.
REQ-011 req_addr  input  16  word address from the memory-access stage.
REQ-012 req_wdata  input  DATA_W  write data.
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  consumer accepts response.
REQ-015 rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
REQ-016 rsp_err  output  1  address out of range (req_addr[15:ADDR_BITS] nonzero).

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-018 req_ready SHALL be 1 only in IDLE with flush low.
REQ-019 Acceptance: a cycle with req_valid & req_ready SHALL capture we, addr and wdata, and SHALL move to WAIT, or to RESP when WAIT_STATES = 0.
REQ-020 WAIT SHALL count WAIT_STATES cycles, then move to RESP; rsp_valid SHALL first be high WAIT_STATES+1 cycles after the acceptance edge.
REQ-021 On entry to RESP, an in-range read SHALL load rsp_rdata from the array and an in-range write SHALL commit wdata to the array.
REQ-022 An out-of-range access SHALL set rsp_err=1 and rsp_rdata=0, and SHALL NOT modify the array.
REQ-023 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_valid & rsp_ready; on that edge the FSM SHALL go to IDLE.
REQ-024 No bypass: the next request SHALL NOT be accepted earlier than the cycle after the response handshake.
REQ-025 flush in WAIT SHALL return to IDLE with no array write and no response.
REQ-026 flush in RESP SHALL drop the response (rsp_valid low next cycle) and return to IDLE; a write already committed SHALL remain committed.
REQ-027 flush and rsp_ready in the same RESP cycle SHALL have the same effect as flush alone; the net state is IDLE.
REQ-028 A read immediately after a write to the same address SHALL return the new data.
REQ-029 The array SHALL be written only in the RESP-entry cycle; all other cycles SHALL leave it unchanged.

Reset
REQ-030 resetn low SHALL force IDLE asynchronously, with rsp_valid=0, rsp_rdata=0, rsp_err=0, the wait counter cleared and captured request fields cleared.
REQ-031 req_ready SHALL read 1 during reset only once resetn has deasserted; during reset it is 0.
REQ-032 Reset mid-transaction SHALL discard the transaction; an uncommitted write SHALL NOT reach the array.
REQ-033 Array contents SHALL NOT be cleared by reset.

Structure
REQ-034 Shared package mem_pkg SHALL hold the FSM state encoding, the DATA_W/address width constants and the WAIT_STATES maximum.
REQ-035 Storage SHALL be a sub-module data_mem_array: 2^ADDR_BITS x DATA_W, synchronous write, combinational read, no reset.

Verification
REQ-036 Write 0xBEEF to address 0x0010 with WAIT_STATES=2 -> rsp_valid at cycle 3 after acceptance, rsp_err=0, rsp_rdata=0; then read 0x0010 -> rsp_rdata=0xBEEF.
REQ-037 Read 0x0100 with ADDR_BITS=8 -> rsp_err=1, rsp_rdata=0; a later read of 0x0000 is unchanged.
REQ-038 Hold rsp_ready low for 5 cycles in RESP -> rsp_valid and rsp_rdata stable throughout, and req_ready=0.
REQ-039 Pulse flush in the first WAIT cycle of a write of 0x1234 to 0x0005 -> no response; a subsequent read of 0x0005 returns the old value.
REQ-040 WAIT_STATES=0 with back-to-back reads, rsp_ready tied high -> one response every 2 cycles with correct data.
REQ-041 Assert resetn low during WAIT -> outputs zero immediately; after release, req_ready=1 and the array holds no partial write.
